// File: rtl/serial_add_sequencer.sv
// Bit-serial sequencer that drives an external combinational full adder LSB-first.
// Define SERIAL_ADD_OVF_EN to register two's-complement overflow; otherwise ovf is tied low.
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             cr;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == SHIFT) && (count == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        case (state)
            SHIFT: begin
                busy   = 1'b1;
                fa_a   = sa[0];
                fa_b   = sb[0];
                fa_cin = cr;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand shifters, carry loop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            cr    <= 1'b0;
            count <= '0;
        end else if (accept) begin
            sa    <= op_a;
            sb    <= op_b;
            cr    <= cin_init;
            count <= '0;
        end else if (state == SHIFT) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            cr    <= fa_cout;
            count <= count + 1'b1;
        end
    end

    // Sum bits enter at the MSB so the first (LSB) sum bit lands in bit 0 after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            result    <= '0;
            carry_out <= 1'b0;
        end else if (state == SHIFT) begin
            result <= {fa_sum, result[WIDTH-1:1]};
            if (last_bit) carry_out <= fa_cout;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the MSB step fa_cin is the carry into the sign bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= fa_cin ^ fa_cout;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer (WIDTH=4) with a behavioural full adder in the loop.
// Expected ovf follows SERIAL_ADD_OVF_EN so the bench matches either build.
module tb_serial_add_sequencer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_init;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    serial_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin_init  (cin_init),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .ovf       (ovf)
    );

    // The full adder the sequencer wraps.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [3:0] s;
        s = a + b + {3'b0, c};
`ifdef SERIAL_ADD_OVF_EN
        return (a[3] == b[3]) && (s[3] != a[3]);
`else
        return 1'b0;
`endif
    endfunction

    // One operation from the start edge until IDLE; alt operands appear on the inputs
    // during SHIFT/DONE when hold_start is set (start stays high until the DONE cycle).
    int         busy_cycles;
    int         done_pulses;
    int         done_at;
    int         cin_ones;
    int         cin_first;
    logic [3:0] res_at_done;
    logic       co_at_done;
    logic       ovf_at_done;

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input bit hold_start);
        @(negedge clk);
        op_a = a; op_b = b; cin_init = c; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        busy_cycles = 0; done_pulses = 0; done_at = -1; cin_ones = 0; cin_first = 0;
        res_at_done = 'x; co_at_done = 1'bx; ovf_at_done = 1'bx;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (hold_start && k == 0) begin
                op_a = 4'b1010; op_b = 4'b0110; cin_init = 1'b1;
            end
            if (busy) begin
                busy_cycles++;
                if (fa_cin) begin
                    cin_ones++;
                    if (k == 0) cin_first = 1;
                end
            end
            if (done) begin
                done_pulses++;
                done_at     = k;
                res_at_done = result;
                co_at_done  = carry_out;
                ovf_at_done = ovf;
                start       = 1'b0;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic c);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {4'b0, c};
        check({tag, "_busy_cycles"}, busy_cycles, 4);
        check({tag, "_done_pulses"}, done_pulses, 1);
        check({tag, "_done_at"}, done_at, 4);
        check({tag, "_result"}, res_at_done, sum[3:0]);
        check({tag, "_carry_out"}, co_at_done, sum[4]);
        check({tag, "_ovf"}, ovf_at_done, exp_ovf(a, b, c));
        check({tag, "_result_held"}, {carry_out, result}, sum);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_init = 1'b0;
        #2;
        check("rst_outputs", {busy, done, fa_a, fa_b, fa_cin, carry_out, ovf, result}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_after_rst", {busy, done}, '0);

        // 1: 5 + 3 = 8, signed overflow.
        run_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        check_op("t1", 4'b0101, 4'b0011, 1'b0);
        check("t1_result_const", res_at_done, 4'b1000);
        check("t1_ovf_const", ovf_at_done, exp_ovf(4'b0101, 4'b0011, 1'b0));

        // 2: 15 + 1 wraps with carry out.
        run_op(4'b1111, 4'b0001, 1'b0, 1'b0);
        check_op("t2", 4'b1111, 4'b0001, 1'b0);
        check("t2_carry_const", {co_at_done, res_at_done}, 5'b10000);

        // 3: only the initial carry; it must die after the first bit.
        run_op(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_op("t3", 4'b0000, 4'b0000, 1'b1);
        check("t3_cin_first", cin_first, 1);
        check("t3_cin_ones", cin_ones, 1);

        // 4: start held with changing operands during SHIFT/DONE.
        run_op(4'b0001, 4'b0010, 1'b0, 1'b1);
        check_op("t4", 4'b0001, 4'b0010, 1'b0);
        check("t4_still_idle", {busy, done}, '0);

        // 5: async reset in the second SHIFT cycle.
        @(negedge clk);
        op_a = 4'b1111; op_b = 4'b1111; cin_init = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_busy_done", {busy, done}, '0);
        check("t5_rst_fa", {fa_a, fa_b, fa_cin}, '0);
        check("t5_rst_result", {ovf, carry_out, result}, '0);
        done_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) done_pulses++;
        end
        check("t5_no_done", done_pulses, 0);
        rst_n = 1'b1;
        run_op(4'b0110, 4'b0111, 1'b1, 1'b0);
        check_op("t5_after", 4'b0110, 4'b0111, 1'b1);

        // 6: every operand/carry combination.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run_op(v[8:5], v[4:1], v[0], 1'b0);
            check_op("sweep", v[8:5], v[4:1], v[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
